// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage. Runs one req/ack data-bus transaction per
// load/store, passes non-memory results through with one cycle of latency, and
// raises misalignment and bus-timeout exceptions.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr
);

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  // Last BUS cycle count before giving up; mem_req stays high TIMEOUT cycles.
  localparam logic [15:0] CntLimit = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] ea_q;

  logic        is_load, is_store, is_half, is_word, misalign;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [31:0] rshift;
  logic [31:0] load_val;

  assign in_ready = (state_q == StIdle);

  // Decode the incoming opcode: access class, size, alignment and bus write fields.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    strb_d   = 4'b0000;
    wdata_d  = 32'h0;
    case (opcode)
      OpLb, OpLbu: is_load = 1'b1;
      OpLh, OpLhu: begin
        is_load = 1'b1;
        is_half = 1'b1;
      end
      OpLw: begin
        is_load = 1'b1;
        is_word = 1'b1;
      end
      OpSb: begin
        is_store = 1'b1;
        strb_d   = 4'b0001 << addr[1:0];
        wdata_d  = {4{store_data[7:0]}};
      end
      OpSh: begin
        is_store = 1'b1;
        is_half  = 1'b1;
        strb_d   = 4'b0011 << addr[1:0];
        wdata_d  = {2{store_data[15:0]}};
      end
      OpSw: begin
        is_store = 1'b1;
        is_word  = 1'b1;
        strb_d   = 4'b1111;
        wdata_d  = store_data;
      end
      default: ;
    endcase
    misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  end

  // Pick the addressed little-endian lane out of the read word and extend it.
  always_comb begin
    rshift = mem_rdata >> {off_q, 3'b000};
    case (op_q)
      OpLb:    load_val = {{24{rshift[7]}}, rshift[7:0]};
      OpLbu:   load_val = {24'h0, rshift[7:0]};
      OpLh:    load_val = {{16{rshift[15]}}, rshift[15:0]};
      OpLhu:   load_val = {16'h0, rshift[15:0]};
      default: load_val = mem_rdata;
    endcase
  end

  // Stage FSM with all outputs registered; wb/exc are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 16'h0;
      op_q      <= 6'h0;
      off_q     <= 2'b00;
      ea_q      <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
      wb_valid  <= 1'b0;
      wb_data   <= 32'h0;
      exc_valid <= 1'b0;
      exc_code  <= 2'b00;
      exc_addr  <= 32'h0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (!(is_load || is_store)) begin
              wb_valid <= 1'b1;
              wb_data  <= addr;
            end else if (misalign) begin
              exc_valid <= 1'b1;
              exc_code  <= is_store ? 2'b10 : 2'b01;
              exc_addr  <= addr;
            end else begin
              state_q   <= StBus;
              cnt_q     <= 16'h0;
              op_q      <= opcode;
              off_q     <= addr[1:0];
              ea_q      <= addr;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= strb_d;
              mem_wdata <= wdata_d;
            end
          end
        end
        StBus: begin
          // Ack takes priority over the timeout limit in the same cycle.
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (!mem_we) begin
              wb_valid <= 1'b1;
              wb_data  <= load_val;
            end
          end else if (cnt_q == CntLimit) begin
            state_q   <= StIdle;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            exc_valid <= 1'b1;
            exc_code  <= 2'b11;
            exc_addr  <= ea_q;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus; a cycle-indexed expectation model filled from
// transaction-level timing rules, checked every cycle by one compare process.
module tb_mem_stage;

  localparam int unsigned TO = 4;
  localparam int NC = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid, exc_valid;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_code;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .exc_addr   (exc_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Expected observable outputs per cycle index.
  bit          e_req[NC];
  bit          e_rdy[NC];
  bit          e_wb[NC];
  logic [31:0] e_wbd[NC];
  bit          e_exc[NC];
  logic [1:0]  e_code[NC];
  logic [31:0] e_eaddr[NC];
  logic [31:0] e_maddr[NC];
  bit          e_we[NC];
  logic [3:0]  e_strb[NC];
  logic [31:0] e_wdata[NC];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic bit f_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit f_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic int f_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic bit f_misaligned(input logic [5:0] op, input logic [31:0] a);
    return (a % 32'(f_size(op))) != 0;
  endfunction

  function automatic logic [3:0] f_strb(input logic [5:0] op, input logic [31:0] a);
    int v;
    if (!f_store(op)) return 4'b0000;
    v = ((1 << f_size(op)) - 1) << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (f_size(op))
      1:       return (rt & 32'hFF) * 32'h01010101;
      2:       return (rt & 32'hFFFF) * 32'h00010001;
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] f_load_val(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = f_size(op);
    if (sz == 4) return rd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * (a % 4))) & mask;
    if ((op == 6'h20 || op == 6'h21) && v >= (mask + 1) / 2) v = v | ~mask;
    return v;
  endfunction

  // Record what an instruction transferred in slot s must make visible later.
  // n = number of req cycles before ack (0: never acked, so it times out).
  function automatic void model_issue(input int s, input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] rt, input int n,
                                      input logic [31:0] rd);
    int m;
    if (!(f_load(op) || f_store(op))) begin
      e_wb[s+1]  = 1'b1;
      e_wbd[s+1] = a;
    end else if (f_misaligned(op, a)) begin
      e_exc[s+1]   = 1'b1;
      e_code[s+1]  = f_store(op) ? 2'b10 : 2'b01;
      e_eaddr[s+1] = a;
    end else begin
      m = (n == 0) ? int'(TO) : n;
      for (int c = s + 1; c <= s + m; c++) begin
        e_req[c]   = 1'b1;
        e_rdy[c]   = 1'b0;
        e_maddr[c] = a & 32'hFFFF_FFFC;
        e_we[c]    = f_store(op);
        e_strb[c]  = f_strb(op, a);
        e_wdata[c] = f_wdata(op, rt);
      end
      if (n == 0) begin
        e_exc[s+m+1]   = 1'b1;
        e_code[s+m+1]  = 2'b11;
        e_eaddr[s+m+1] = a;
      end else if (f_load(op)) begin
        e_wb[s+m+1]  = 1'b1;
        e_wbd[s+m+1] = f_load_val(op, a, rd);
      end
    end
  endfunction

  // Compare process: every cycle out of reset, outputs versus the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (cyc >= NC) begin
        chk("cycle_budget", 32'(cyc), 32'(NC - 1));
      end else begin
        chk("in_ready", {31'h0, in_ready}, {31'h0, e_rdy[cyc]});
        chk("mem_req", {31'h0, mem_req}, {31'h0, e_req[cyc]});
        chk("wb_valid", {31'h0, wb_valid}, {31'h0, e_wb[cyc]});
        chk("exc_valid", {31'h0, exc_valid}, {31'h0, e_exc[cyc]});
        if (e_wb[cyc]) chk("wb_data", wb_data, e_wbd[cyc]);
        if (e_exc[cyc]) begin
          chk("exc_code", {30'h0, exc_code}, {30'h0, e_code[cyc]});
          chk("exc_addr", exc_addr, e_eaddr[cyc]);
        end
        if (e_req[cyc]) begin
          chk("mem_addr", mem_addr, e_maddr[cyc]);
          chk("mem_we", {31'h0, mem_we}, {31'h0, e_we[cyc]});
          chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e_strb[cyc]});
          if (e_we[cyc]) chk("mem_wdata", mem_wdata, e_wdata[cyc]);
        end
      end
    end
  end

  // Transfer one instruction in the current slot and answer the bus after n req cycles.
  // Returns in the slot where the result (wb/exc) is visible.
  task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                     input int n, input logic [31:0] rd);
    int s;
    s = cyc;
    model_issue(s, op, a, rt, n, rd);
    in_valid = 1'b1;
    opcode = op;
    addr = a;
    store_data = rt;
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 6'h0;
    addr = 32'h0;
    store_data = 32'h0;
    if ((f_load(op) || f_store(op)) && !f_misaligned(op, a)) begin
      if (n > 0) begin
        repeat (n - 1) @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
      end else begin
        repeat (TO) @(negedge clk);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < NC; i++) begin
      e_req[i] = 1'b0;
      e_rdy[i] = 1'b1;
      e_wb[i] = 1'b0;
      e_exc[i] = 1'b0;
    end

    // Reset values while held in reset.
    #3;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("rst_exc_valid", {31'h0, exc_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_exc_addr", exc_addr, 32'h0);
    chk("rst_exc_code", {30'h0, exc_code}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, in_ready}, 32'h1);
    chk_en = 1'b1;

    // Hand-computed pins on the model itself.
    chk("pin_lb", f_load_val(6'h20, 32'h1003, 32'h80FFEEDD), 32'hFFFFFF80);
    chk("pin_lbu", f_load_val(6'h24, 32'h1003, 32'h80FFEEDD), 32'h00000080);
    chk("pin_lh", f_load_val(6'h21, 32'h4002, 32'h8001_1234), 32'hFFFF8001);
    chk("pin_sh_strb", {28'h0, f_strb(6'h29, 32'h2002)}, 32'hC);
    chk("pin_sh_wdata", f_wdata(6'h29, 32'hCAFEBEEF), 32'hBEEFBEEF);
    chk("pin_sb_strb", {28'h0, f_strb(6'h28, 32'h4003)}, 32'h8);

    // Pass-through, then back-to-back pass-throughs.
    run(6'h00, 32'h12345678, 32'h0, 0, 32'h0);
    chk("pt_wb_data", wb_data, 32'h12345678);
    run(6'h0F, 32'hA5A5_0001, 32'h0, 0, 32'h0);
    run(6'h3F, 32'h0000_BEEF, 32'h0, 0, 32'h0);
    chk("pt_b2b_data", wb_data, 32'h0000_BEEF);

    // LB / LBU from byte lane 3, ack on 3rd req cycle.
    run(6'h20, 32'h1003, 32'h0, 3, 32'h80FFEEDD);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    run(6'h24, 32'h1003, 32'h0, 3, 32'h80FFEEDD);
    chk("lbu_wb_data", wb_data, 32'h00000080);

    // SH upper half, ack on first req cycle.
    run(6'h29, 32'h2002, 32'hCAFEBEEF, 1, 32'h0);
    chk("sh_no_wb", {31'h0, wb_valid}, 32'h0);
    chk("sh_ready", {31'h0, in_ready}, 32'h1);

    // Misalignment exceptions.
    run(6'h23, 32'h3001, 32'h0, 1, 32'h0);
    chk("lw_mis_code", {30'h0, exc_code}, 32'h1);
    chk("lw_mis_addr", exc_addr, 32'h3001);
    run(6'h2B, 32'h3002, 32'h0, 1, 32'h0);
    chk("sw_mis_code", {30'h0, exc_code}, 32'h2);
    run(6'h25, 32'h4001, 32'h0, 1, 32'h0);

    // Other lanes and sizes.
    run(6'h28, 32'h4003, 32'h1234_56A7, 2, 32'h0);
    run(6'h25, 32'h4002, 32'h0, 1, 32'h8001_1234);
    chk("lhu_wb_data", wb_data, 32'h0000_8001);
    run(6'h21, 32'h4002, 32'h0, 2, 32'h8001_1234);
    run(6'h23, 32'h4004, 32'h0, 1, 32'hDEAD_BEEF);
    chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    run(6'h2B, 32'h4008, 32'h0BAD_F00D, 2, 32'h0);

    // Timeout, then ack exactly on the limit cycle.
    run(6'h2B, 32'h5000, 32'h1111_2222, 0, 32'h0);
    chk("to_code", {30'h0, exc_code}, 32'h3);
    chk("to_addr", exc_addr, 32'h5000);
    run(6'h23, 32'h5004, 32'h0, int'(TO), 32'h7777_8888);
    chk("ack_at_limit_no_exc", {31'h0, exc_valid}, 32'h0);

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset asserted during the 2nd req cycle of an LW.
    s = cyc;
    model_issue(s, 6'h23, 32'h6000, 32'h0, 3, 32'h0);
    in_valid = 1'b1;
    opcode = 6'h23;
    addr = 32'h6000;
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 6'h0;
    addr = 32'h0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int c = s + 3; c < s + 12; c++) begin
      e_req[c] = 1'b0;
      e_rdy[c] = 1'b1;
      e_wb[c] = 1'b0;
      e_exc[c] = 1'b0;
    end
    #1;
    chk("rst_mid_bus_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run(6'h23, 32'h6008, 32'h0, 2, 32'h1122_3344);
    chk("post_rst_lw", wb_data, 32'h1122_3344);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the MIPS datapath, directly downstream of the ALU. It takes the ALU result (effective address, or plain result for non-memory instructions), the opcode and the store operand from execute. It runs one request/acknowledge transaction on the data-memory bus for loads and stores, and produces write-back data or an exception. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of cycles mem_req may stay high without mem_ack before a bus-timeout exception is raised (range 1..65535).

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction from execute is present this cycle
- in_ready  out  1  stage accepts an instruction this cycle (high only in IDLE)
- opcode  in  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; any other value is non-memory
- addr  in  32  ALU result: effective address for memory ops, pass-through result otherwise
- store_data  in  32  rt value for stores
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  write data, lane-replicated
- mem_wstrb  out  4  byte enables; 0000 for reads
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read data, valid in the mem_ack cycle
- wb_valid  out  1  one-cycle pulse: wb_data is valid
- wb_data  out  32  load result or pass-through result
- exc_valid  out  1  one-cycle pulse: exception
- exc_code  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout
- exc_addr  out  32  full (unaligned) effective address of the faulting instruction

## Operation
- States: IDLE, BUS. Transfer occurs when in_valid && in_ready.
- IDLE, transfer of a non-memory opcode: stay IDLE. Next cycle wb_valid=1 and wb_data=addr.
- IDLE, transfer of a memory op with misaligned address: stay IDLE. Next cycle exc_valid=1 with exc_code and exc_addr. No bus activity. Alignment rules:
  - LH/LHU/SH: addr[0]!=0 is misaligned.
  - LW/SW: addr[1:0]!=0 is misaligned.
  - Byte ops never fault.
- IDLE, transfer of an aligned memory op: capture all request fields and go to BUS.
- Captured request fields:
  - mem_addr = {addr[31:2],2'b00}; off = addr[1:0].
  - mem_we = 1 for stores.
  - mem_wstrb: SB 0001<<off, SH 0011<<off, SW 1111, loads 0000.
  - mem_wdata: SB {4{rt[7:0]}}, SH {2{rt[15:0]}}, SW rt.
- BUS: mem_req=1, with addr/we/wdata/wstrb held stable until completion.
- mem_ack high in BUS: go to IDLE.
  - Loads: next cycle wb_valid=1, with wb_data taken from mem_rdata sampled in the ack cycle, little-endian lanes.
  - LB/LBU: rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: rdata[8*off+:16], sign- or zero-extended.
  - LW: full word.
  - Stores produce no wb_valid.
- Timeout: a 16-bit counter clears on entry to BUS and increments each BUS cycle without ack. When the count reaches TIMEOUT-1 with no ack, go to IDLE; next cycle exc_valid=1, exc_code=11, exc_addr=captured address.
- Ack in the same cycle as the timeout limit: ack wins, no exception.
- mem_ack while mem_req=0 is ignored.
- wb_valid and exc_valid are never high together.

## Timing
- Reset (async assert): state IDLE; mem_req, mem_we, wb_valid, exc_valid = 0; mem_addr, mem_wdata, wb_data, exc_addr = 0; mem_wstrb = 0000; exc_code = 00; counter = 0. in_ready=1 once rst_n is released.
- Reset asserted mid-BUS: mem_req drops immediately; the pending result is discarded with no wb/exc pulse.
- Non-memory latency: wb_valid 1 cycle after transfer; back-to-back transfers give one result per cycle.
- Memory latency: mem_req rises 1 cycle after transfer. With ack in the first req cycle, wb_valid occurs 2 cycles after transfer.
- in_ready is low for the whole BUS state. It is high again in the cycle after the ack, which is the cycle wb_valid pulses, so a new transfer may occur in that cycle.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then exc_valid pulses the following cycle.
- All outputs are registered except in_ready, which is decoded from state.

## Test plan
- Pass-through: transfer opcode 0x00, addr=0x12345678 -> one cycle later wb_valid=1, wb_data=0x12345678, mem_req stays 0.
- LB sign extend: addr=0x1003, ack after 3 cycles with rdata=0x80FFEEDD -> mem_addr=0x1000, wstrb=0000, mem_req high 3 cycles, then wb_data=0xFFFFFF80. The same access with LBU gives 0x00000080.
- SH lanes: addr=0x2002, rt=0xCAFEBEEF, ack first cycle -> mem_we=1, wstrb=1100, wdata=0xBEEFBEEF; no wb_valid; in_ready high 2 cycles after transfer.
- Misaligned: LW addr=0x3001 -> exc_valid next cycle, exc_code=01, exc_addr=0x3001, mem_req never asserted. SW addr=0x3002 gives exc_code=10.
- Timeout with TIMEOUT=4 and no ack -> mem_req high exactly 4 cycles, then exc_code=11. Repeat with ack in the 4th cycle -> normal completion, no exception.
- Reset mid-BUS: drop rst_n during the 2nd req cycle -> mem_req=0 immediately; no wb/exc pulse after release; next LW completes normally.
